// File: rtl/input_debouncer.sv
// input_debouncer: per-channel two-flop synchroniser and stability-counter FSM producing
// a clean level plus press/release pulses. Auto-repeat pulses exist only when DEBOUNCE_AUTOREPEAT_EN is defined.
module input_debouncer #(
    parameter int CHANNELS      = 4,
    parameter int STABLE_CYCLES = 500000,
    parameter bit ACTIVE_LOW    = 1'b1,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] raw_in,
    output logic [CHANNELS-1:0] level_out,
    output logic [CHANNELS-1:0] press_pulse,
    output logic [CHANNELS-1:0] release_pulse,
    output logic [CHANNELS-1:0] repeat_pulse
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        S_RELEASED        = 2'd0,
        S_CONFIRM_PRESS   = 2'd1,
        S_PRESSED         = 2'd2,
        S_CONFIRM_RELEASE = 2'd3
    } state_e;

    if ((CHANNELS < 32'sd1) || (CHANNELS > 32'sd32) || (STABLE_CYCLES < 32'sd1) ||
        (REPEAT_DELAY < 32'sd1) || (REPEAT_PERIOD < 32'sd1)) begin : g_param_check
        $error("input_debouncer: parameter out of range");
    end

    // Saturating increment: the stability counter must never wrap.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        if (v == CNT_MAX) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_ONE;
        end
    endfunction

    logic [CHANNELS-1:0] sync1_d, sync1_q;
    logic [CHANNELS-1:0] s_q;
    state_e              state_d [CHANNELS];
    state_e              state_q [CHANNELS];
    logic [CW-1:0]       cnt_d   [CHANNELS];
    logic [CW-1:0]       cnt_q   [CHANNELS];
    logic [CHANNELS-1:0] level_d, level_q;
    logic [CHANNELS-1:0] press_d, press_q;
    logic [CHANNELS-1:0] release_d, release_q;

    // Polarity normalisation ahead of the synchroniser: 1 always means pressed.
    always_comb begin
        sync1_d = raw_in ^ {CHANNELS{ACTIVE_LOW}};
    end

    // Per-channel debounce FSM: next state, counter and registered-output values.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i]   = state_q[i];
            cnt_d[i]     = cnt_q[i];
            level_d[i]   = level_q[i];
            press_d[i]   = 1'b0;
            release_d[i] = 1'b0;
            case (state_q[i])
                S_RELEASED: begin
                    if (s_q[i]) begin
                        if (STABLE_CYCLES <= 32'sd1) begin
                            state_d[i] = S_PRESSED;
                            cnt_d[i]   = '0;
                            level_d[i] = 1'b1;
                            press_d[i] = 1'b1;
                        end else begin
                            state_d[i] = S_CONFIRM_PRESS;
                            cnt_d[i]   = CNT_ONE;
                        end
                    end else begin
                        cnt_d[i] = '0;
                    end
                end
                S_CONFIRM_PRESS: begin
                    if (!s_q[i]) begin
                        state_d[i] = S_RELEASED;
                        cnt_d[i]   = '0;
                    end else if (sat_inc(cnt_q[i]) == CNT_MAX) begin
                        state_d[i] = S_PRESSED;
                        cnt_d[i]   = '0;
                        level_d[i] = 1'b1;
                        press_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = sat_inc(cnt_q[i]);
                    end
                end
                S_PRESSED: begin
                    if (!s_q[i]) begin
                        if (STABLE_CYCLES <= 32'sd1) begin
                            state_d[i]   = S_RELEASED;
                            cnt_d[i]     = '0;
                            level_d[i]   = 1'b0;
                            release_d[i] = 1'b1;
                        end else begin
                            state_d[i] = S_CONFIRM_RELEASE;
                            cnt_d[i]   = CNT_ONE;
                        end
                    end else begin
                        cnt_d[i] = '0;
                    end
                end
                S_CONFIRM_RELEASE: begin
                    if (s_q[i]) begin
                        state_d[i] = S_PRESSED;
                        cnt_d[i]   = '0;
                    end else if (sat_inc(cnt_q[i]) == CNT_MAX) begin
                        state_d[i]   = S_RELEASED;
                        cnt_d[i]     = '0;
                        level_d[i]   = 1'b0;
                        release_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = sat_inc(cnt_q[i]);
                    end
                end
                default: begin
                    state_d[i] = S_RELEASED;
                    cnt_d[i]   = '0;
                    level_d[i] = 1'b0;
                end
            endcase
        end
    end

    // Synchroniser, FSM state and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q   <= '0;
            s_q       <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= S_RELEASED;
                cnt_q[i]   <= '0;
            end
        end else begin
            sync1_q   <= sync1_d;
            s_q       <= sync1_q;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign level_out     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

`ifdef DEBOUNCE_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] DELAY_M1  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_M1 = RW'(REPEAT_PERIOD - 1);
    localparam logic [RW-1:0] RCNT_ONE  = RW'(1);

    logic [RW-1:0]       rcnt_d   [CHANNELS];
    logic [RW-1:0]       rcnt_q   [CHANNELS];
    logic [CHANNELS-1:0] rphase_d, rphase_q;
    logic [CHANNELS-1:0] repeat_d, repeat_q;

    // Repeat timer: advances only while a channel stays in PRESSED, so CONFIRM_RELEASE freezes it.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            rcnt_d[i]   = rcnt_q[i];
            rphase_d[i] = rphase_q[i];
            repeat_d[i] = 1'b0;
            if (press_d[i] || release_d[i]) begin
                rcnt_d[i]   = '0;
                rphase_d[i] = 1'b0;
            end else if ((state_q[i] == S_PRESSED) && (state_d[i] == S_PRESSED)) begin
                if (rcnt_q[i] == (rphase_q[i] ? PERIOD_M1 : DELAY_M1)) begin
                    rcnt_d[i]   = '0;
                    rphase_d[i] = 1'b1;
                    repeat_d[i] = 1'b1;
                end else begin
                    rcnt_d[i] = rcnt_q[i] + RCNT_ONE;
                end
            end else begin
                rcnt_d[i] = rcnt_q[i];
            end
        end
    end

    // Repeat timer and repeat-pulse registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            rphase_q <= '0;
            repeat_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                rcnt_q[i] <= '0;
            end
        end else begin
            rphase_q <= rphase_d;
            repeat_q <= repeat_d;
            for (int i = 0; i < CHANNELS; i++) begin
                rcnt_q[i] <= rcnt_d[i];
            end
        end
    end

    assign repeat_pulse = repeat_q;
`else
    assign repeat_pulse = {CHANNELS{1'b0}};
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: directed checks of reset, press/release latency, bounce rejection,
// reset mid-confirmation, auto-repeat timing and simultaneous channels.
module tb_input_debouncer;

    logic       clock;
    logic       reset;
    logic [3:0] raw_in;
    logic [3:0] level_out;
    logic [3:0] press_pulse;
    logic [3:0] release_pulse;
    logic [3:0] repeat_pulse;

    int tests_run;
    int tests_failed;

    input_debouncer #(
        .CHANNELS      (4),
        .STABLE_CYCLES (4),
        .ACTIVE_LOW    (1'b1),
        .REPEAT_DELAY  (10),
        .REPEAT_PERIOD (5)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .raw_in        (raw_in),
        .level_out     (level_out),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .repeat_pulse  (repeat_pulse)
    );

    // 50 MHz clock
    initial begin
        clock = 1'b0;
        forever #10 clock = ~clock;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic expect_out(input string tag, input logic [3:0] lvl, input logic [3:0] prs,
                              input logic [3:0] rel, input logic [3:0] rpt);
        check_eq({tag, ".level"},   {28'd0, level_out},     {28'd0, lvl});
        check_eq({tag, ".press"},   {28'd0, press_pulse},   {28'd0, prs});
        check_eq({tag, ".release"}, {28'd0, release_pulse}, {28'd0, rel});
        check_eq({tag, ".repeat"},  {28'd0, repeat_pulse},  {28'd0, rpt});
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Press on mask, hold 8 cycles, then release: pulse 6 cycles after each input change.
    task automatic press_release(input string tag, input logic [3:0] mask);
        raw_in = ~mask;
        for (int n = 1; n <= 8; n++) begin
            step();
            expect_out({tag, ".prs"}, (n >= 6) ? mask : 4'b0000, (n == 6) ? mask : 4'b0000,
                       4'b0000, 4'b0000);
        end
        raw_in = 4'b1111;
        for (int n = 1; n <= 8; n++) begin
            step();
            expect_out({tag, ".rel"}, (n >= 6) ? 4'b0000 : mask, 4'b0000,
                       (n == 6) ? mask : 4'b0000, 4'b0000);
        end
    endtask

    logic [3:0] exp_rpt;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        raw_in       = 4'b1111;

        // 1: reset state
        for (int n = 0; n < 3; n++) begin
            step();
            expect_out("rst_hold", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        end
        reset = 1'b0;
        for (int n = 0; n < 20; n++) begin
            step();
            expect_out("rst_idle", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        end

        // 2: clean press/release on channels 1 and 2
        press_release("clean", 4'b0110);

        // 3: bounce rejection on channel 0, then a clean press
        for (int j = 0; j < 20; j++) begin
            raw_in = {3'b111, (((j / 2) % 2) == 1)};
            step();
            expect_out("bounce", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        end
        press_release("bounce_end", 4'b0001);

        // 4: reset during confirmation restarts detection
        raw_in = 4'b1110;
        for (int n = 0; n < 3; n++) begin
            step();
            expect_out("midrst_pre", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        end
        reset = 1'b1;
        step();
        expect_out("midrst_in", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        reset = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            step();
            expect_out("midrst_post", (n >= 6) ? 4'b0001 : 4'b0000,
                       (n == 6) ? 4'b0001 : 4'b0000, 4'b0000, 4'b0000);
        end
        raw_in = 4'b1111;
        for (int n = 1; n <= 8; n++) begin
            step();
            expect_out("midrst_rel", (n >= 6) ? 4'b0000 : 4'b0001, 4'b0000,
                       (n == 6) ? 4'b0001 : 4'b0000, 4'b0000);
        end

        // 5: channel 3 held for 40 cycles; repeats 10,15..35 cycles after the press
        raw_in = 4'b0111;
        for (int n = 1; n <= 50; n++) begin
            step();
`ifdef DEBOUNCE_AUTOREPEAT_EN
            exp_rpt = ((n >= 16) && (n <= 41) && (((n - 16) % 5) == 0)) ? 4'b1000 : 4'b0000;
`else
            exp_rpt = 4'b0000;
`endif
            expect_out("repeat", ((n >= 6) && (n <= 45)) ? 4'b1000 : 4'b0000,
                       (n == 6) ? 4'b1000 : 4'b0000, (n == 46) ? 4'b1000 : 4'b0000, exp_rpt);
            if (n == 40) begin
                raw_in = 4'b1111;
            end
        end

        // 6: all channels together
        press_release("all", 4'b1111);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
